// File: rtl/seg_display_scheduler_if.sv
// Bundle between the two frame sources and the display scheduler: requests and
// frames in, grants, frame tick and the multiplexed display drive out.
interface seg_display_scheduler_if;
  logic        req0;
  logic [31:0] frame0;
  logic        req1;
  logic [31:0] frame1;
  logic        gnt0;
  logic        gnt1;
  logic        frame_tick;
  logic [3:0]  digit_sel;
  logic [7:0]  segments;

  modport master (
    output req0, frame0, req1, frame1,
    input  gnt0, gnt1, frame_tick, digit_sel, segments
  );

  modport slave (
    input  req0, frame0, req1, frame1,
    output gnt0, gnt1, frame_tick, digit_sel, segments
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Shares a 4-digit multiplexed 7-segment display between a low- and a high-priority
// frame source; ownership only changes at frame boundaries, with a minimum hold.
module seg_display_scheduler #(
  parameter int REFRESH_CYCLES = 50_000,
  parameter int BLANK_CYCLES   = 500,
  parameter int HOLD_FRAMES    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seg_display_scheduler_if.slave  bus
);

  localparam int CNT_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT   = HW'(HOLD_FRAMES);
  localparam logic [HW:0]   HOLD_REQ   = (HW + 1)'(HOLD_FRAMES);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} owner_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            first_q;
  owner_t          owner_q, owner_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [3:0]      digit_sel_q, digit_sel_d;
  logic [7:0]      segments_q, segments_d;
  logic            tick_q;
  logic            boundary;
  logic            hold_done;

  // The frame that ends at this boundary counts toward the hold requirement.
  assign hold_done = ({1'b0, hold_q} + (HW + 1)'(1)) >= HOLD_REQ;
  assign boundary  = first_q |
                     ((state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST) && (idx_q == 2'd3));

  // NOTE: state register uses non-blocking assignments so every flop samples
  // pre-edge values; async reset also clears the shadow frame buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      first_q     <= 1'b1;
      owner_q     <= OWN_NONE;
      hold_q      <= '0;
      shadow_q    <= 32'hFFFF_FFFF;
      digit_sel_q <= 4'b1111;
      segments_q  <= 8'hFF;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      first_q     <= 1'b0;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      shadow_q    <= shadow_d;
      digit_sel_q <= digit_sel_d;
      segments_q  <= segments_d;
      tick_q      <= boundary;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    digit_sel_d = digit_sel_q;
    segments_d  = segments_q;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d     = ST_DRIVE;
          cnt_d       = '0;
          digit_sel_d = ~(4'b0001 << idx_q);
          segments_d  = shadow_q[{idx_q, 3'b000} +: 8];
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d     = ST_BLANK;
          cnt_d       = '0;
          idx_d       = idx_q + 2'd1;
          digit_sel_d = 4'b1111;
          segments_d  = 8'hFF;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Ownership, hold count and shadow frame move only on a boundary edge.
  always_comb begin
    owner_d  = owner_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    if (boundary) begin
      unique case (owner_q)
        OWN_0: begin
          if (!bus.req0)                   owner_d = bus.req1 ? OWN_1 : OWN_NONE;
          else if (bus.req1 && hold_done)  owner_d = OWN_1;
        end
        default: begin
          if (bus.req1)      owner_d = OWN_1;
          else if (bus.req0) owner_d = OWN_0;
          else               owner_d = OWN_NONE;
        end
      endcase

      if (owner_d != owner_q)   hold_d = '0;
      else if (hold_q < HOLD_SAT) hold_d = hold_q + HW'(1);

      unique case (owner_d)
        OWN_0:   shadow_d = bus.frame0;
        OWN_1:   shadow_d = bus.frame1;
        default: shadow_d = 32'hFFFF_FFFF;
      endcase
    end
  end

  assign bus.gnt0       = (owner_q == OWN_0);
  assign bus.gnt1       = (owner_q == OWN_1);
  assign bus.frame_tick = tick_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.segments   = segments_q;

endmodule
